phase_freq_tracker: RTL

Downstream consumer of the arctangent stage. Takes the 16-bit angle samples, where 65536 counts equal one full turn (2π), and converts them to per-sample phase deltas, i.e. instantaneous frequency. It also keeps a boxcar-averaged frequency over a power-of-two window and, optionally, an unwrapped 32-bit phase. Valid/ready on both sides; one sample per clock at full throughput.

---
 rtl/phase_freq_tracker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/phase_freq_tracker.sv
// Converts 16-bit angle samples into signed per-sample phase deltas, a boxcar-averaged frequency and an unwrapped phase.
// The outputs appear one cycle after a sample is accepted. One sample per clock is accepted at full throughput.
// When the output is stalled, in_ready falls and all outputs hold. The optional PHASE_UNWRAP_EN macro enables the phase accumulator.
module phase_freq_tracker #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [15:0] angle_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] freq_out,
    output logic [15:0] freq_avg,
    output logic        avg_valid,
    output logic [31:0] phase_unw,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 16 + AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           prev_angle_q, prev_angle_d;
    logic [15:0]           freq_out_q, freq_out_d;
    logic [15:0]           freq_avg_q, freq_avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           win_q [N];
    logic [15:0]           win_d [N];
    logic [AVG_LOG2-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [FW-1:0]         fill_q, fill_d;

    logic                  accept;
    logic                  out_xfer;
    logic [15:0]           delta;
    logic [15:0]           oldest;
    logic [SW-1:0]         sum_next;

    // A new sample may enter whenever the output slot is free or draining; flush blocks entry.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign freq_out  = freq_out_q;
    assign freq_avg  = freq_avg_q;
    assign avg_valid = avg_valid_q;
    assign out_valid = out_valid_q;

`ifdef PHASE_UNWRAP_EN
    logic [31:0] phase_q, phase_d;
    assign phase_unw = phase_q;
`else
    assign phase_unw = 32'd0;
`endif

    // Next-state logic: priming, delta computation, window update, flush and handshake.
    always_comb begin
        state_d      = state_q;
        prev_angle_d = prev_angle_q;
        freq_out_d   = freq_out_q;
        freq_avg_d   = freq_avg_q;
        avg_valid_d  = avg_valid_q;
        out_valid_d  = out_valid_q;
        win_d        = win_q;
        ptr_d        = ptr_q;
        sum_d        = sum_q;
        fill_d       = fill_q;
`ifdef PHASE_UNWRAP_EN
        phase_d      = phase_q;
`endif

        // The modulo-2^16 difference read as signed is exactly the shortest-turn phase step.
        delta    = angle_in - prev_angle_q;
        oldest   = win_q[ptr_q];
        sum_next = sum_q + {{AVG_LOG2{delta[15]}}, delta}
                         - {{AVG_LOG2{oldest[15]}}, oldest};

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d     = PRIME;
            out_valid_d = 1'b0;
            avg_valid_d = 1'b0;
            sum_d       = '0;
            fill_d      = '0;
            ptr_d       = '0;
            for (int i = 0; i < N; i++) begin
                win_d[i] = '0;
            end
        end else if (accept) begin
            prev_angle_d = angle_in;
            case (state_q)
                PRIME: begin
                    state_d = TRACK;
`ifdef PHASE_UNWRAP_EN
                    phase_d = {16'd0, angle_in};
`endif
                end
                TRACK: begin
                    freq_out_d   = delta;
                    out_valid_d  = 1'b1;
                    win_d[ptr_q] = delta;
                    ptr_d        = ptr_q + 1'b1;
                    sum_d        = sum_next;
                    fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                    // The top 16 bits of the sum are the arithmetic shift by AVG_LOG2 (floor).
                    freq_avg_d   = sum_next[SW-1 -: 16];
                    avg_valid_d  = (fill_d == FILL_MAX);
`ifdef PHASE_UNWRAP_EN
                    phase_d      = phase_q + {{16{delta[15]}}, delta};
`endif
                end
                default: state_d = PRIME;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PRIME;
            prev_angle_q <= '0;
            freq_out_q   <= '0;
            freq_avg_q   <= '0;
            avg_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            ptr_q        <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
`ifdef PHASE_UNWRAP_EN
            phase_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prev_angle_q <= prev_angle_d;
            freq_out_q   <= freq_out_d;
            freq_avg_q   <= freq_avg_d;
            avg_valid_q  <= avg_valid_d;
            out_valid_q  <= out_valid_d;
            ptr_q        <= ptr_d;
            sum_q        <= sum_d;
            fill_q       <= fill_d;
            win_q        <= win_d;
`ifdef PHASE_UNWRAP_EN
            phase_q      <= phase_d;
`endif
        end
    end

endmodule
